// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write arbiter, its requesters and the async FIFO write port.
// master: requesters plus FIFO flag side. slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            owner;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_full;

    modport master (
        output req, req_last, req_data, fifo_full,
        input  gnt, owner, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req, req_last, req_data, fifo_full,
        output gnt, owner, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port (write clock domain).
// Build option FIFO_ARB_BURST_EN: when defined, ownership is locked for a whole
// packet (until req_last or MAX_BURST words); otherwise ownership rotates after
// every accepted word and req_last is ignored.
//
// state  | meaning
// S_IDLE | no owner, waiting for any request (owner = 0)
// S_OWN  | one requester owns the FIFO write port (owner one-hot)
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    fifo_wr_arbiter_if.slave        if_bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_owner;
    logic [IDX_WIDTH-1:0]   r_rr_ptr;

    logic [IDX_WIDTH-1:0]   w_own_idx;
    logic [IDX_WIDTH-1:0]   w_start_idx;
    logic [IDX_WIDTH-1:0]   w_scan_idx;
    logic [IDX_WIDTH-1:0]   w_pick_idx;
    logic                   w_pick_found;
    logic                   w_own_req;
    logic                   w_acc;
    logic                   w_rel;
    logic                   w_drop;

    // Modulo-NUM_REQ increment; safe for non-power-of-2 requester counts.
    function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

    // Encode the one-hot owner into an index.
    always_comb begin
        w_own_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner[i])
                w_own_idx = IDX_WIDTH'(i);
        end
    end

    // Scan start: rr pointer when idle, the slot after the owner on handover,
    // so the current owner is considered last.
    assign w_start_idx = (r_state == S_OWN) ? idx_inc(w_own_idx) : r_rr_ptr;

    // First asserted request scanning from w_start_idx with wrap.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = w_start_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_pick_found && if_bus.req[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
            w_scan_idx = idx_inc(w_scan_idx);
        end
    end

    // Reset gates the write path so a packet cut by reset sees no further write.
    assign w_own_req           = if_bus.req[w_own_idx];
    assign w_acc               = (r_state == S_OWN) & w_own_req & ~if_bus.fifo_full & ~i_rst;
    assign if_bus.gnt          = r_owner & {NUM_REQ{w_acc}};
    assign if_bus.fifo_wr_en   = w_acc;
    assign if_bus.fifo_wr_data = ((r_state == S_OWN) && !i_rst)
                               ? if_bus.req_data[int'(w_own_idx)*DATA_WIDTH +: DATA_WIDTH]
                               : '0;
    assign if_bus.owner        = r_owner;

`ifdef FIFO_ARB_BURST_EN
    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    assign w_cnt_inc = r_burst_cnt + 1'b1;
    assign w_rel     = w_acc & (if_bus.req_last[w_own_idx] | (w_cnt_inc == CNT_WIDTH'(MAX_BURST)));
    // A stalled requester keeps the lock once its packet has started.
    assign w_drop    = (r_state == S_OWN) & ~w_own_req & (r_burst_cnt == '0);

    // Words accepted so far in the current ownership; frozen while full.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_burst_cnt <= '0;
        else if (w_rel || w_drop)
            r_burst_cnt <= '0;
        else if (w_acc)
            r_burst_cnt <= w_cnt_inc;
    end
`else
    logic                 w_unused_last;
    logic [CNT_WIDTH-1:0] w_unused_cfg;

    assign w_rel         = w_acc;
    assign w_drop        = (r_state == S_OWN) & ~w_own_req;
    assign w_unused_last = ^if_bus.req_last;
    assign w_unused_cfg  = CNT_WIDTH'(MAX_BURST);
`endif

    // Ownership FSM: grant from idle, hand over on release without a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_owner <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_rel || w_drop) begin
                        r_rr_ptr <= idx_inc(w_own_idx);
                        if (w_pick_found) begin
                            r_owner <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        end else begin
                            r_owner <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_owner <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=8).
// Expected writes are queued by the stimulus; a negedge monitor pops and
// compares on every fifo_wr_en. Burst-lock scenarios run when FIFO_ARB_BURST_EN
// is defined.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) u_if ();

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(8), .IDX_WIDTH(2), .CNT_WIDTH(8)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_bus (u_if)
    );

    exp_t         q_exp[$];
    int           checks   = 0;
    int           failures = 0;
    int           rem[N];
    int           widx[N];
    logic [N-1:0] g_last = '0;

    function automatic logic [DW-1:0] word(input int i, input int w);
        return {4'hA, 4'(i), 8'h00, 16'(w)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            u_if.req[i]             = (rem[i] > 0);
            u_if.req_last[i]        = (rem[i] == 1);
            u_if.req_data[i*DW +: DW] = word(i, widx[i]);
        end
    endtask

    task automatic load(input int i, input int n);
        rem[i]  = n;
        widx[i] = 0;
        apply();
    endtask

    task automatic push_seq(input int i, input int w0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.gnt  = N'(1 << i);
            e.data = word(i, w0 + k);
            q_exp.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_run(input int n);
        for (int k = 0; k < n; k++) begin
            check("wr_run", 32'(u_if.fifo_wr_en), 32'd1);
            tick();
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        int busy;
        k = 0;
        busy = 1;
        while (busy != 0 && k < budget) begin
            busy = q_exp.size();
            for (int i = 0; i < N; i++) busy += rem[i];
            if (busy != 0) begin
                tick();
                k++;
            end
        end
        check("drain_pending", 32'(q_exp.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Monitor: record grants for the requester model and score every write.
    always @(negedge clk) begin
        exp_t e;
        g_last = u_if.gnt;
        if (u_if.fifo_wr_en === 1'b1) begin
            if (q_exp.size() == 0) begin
                check("unexpected_write", 32'(u_if.fifo_wr_en), 32'd0);
            end else begin
                e = q_exp.pop_front();
                check("wr_gnt", 32'(u_if.gnt), 32'(e.gnt));
                check("wr_data", u_if.fifo_wr_data, e.data);
            end
        end
    end

    // Requester model: advance a requester after its word was granted.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g_last[i] === 1'b1) begin
                if (rem[i] > 0) rem[i]--;
                widx[i]++;
            end
        end
        apply();
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        u_if.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            widx[i] = 0;
        end
        apply();

        // Reset held 3 cycles with all requesters active (2-word packets).
        for (int i = 0; i < N; i++) load(i, 2);
`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < N; i++) push_seq(i, 0, 2);
`else
        push_seq(0, 0, 1); push_seq(1, 0, 1); push_seq(2, 0, 1); push_seq(3, 0, 1);
        push_seq(0, 1, 1); push_seq(1, 1, 1); push_seq(2, 1, 1); push_seq(3, 1, 1);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_owner", 32'(u_if.owner), 32'd0);
            check("rst_gnt", 32'(u_if.gnt), 32'd0);
            check("rst_wr_en", 32'(u_if.fifo_wr_en), 32'd0);
            check("rst_data", u_if.fifo_wr_data, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_gnt", 32'(u_if.gnt), 32'd0);
        check("post_rst_data", u_if.fifo_wr_data, 32'd0);
        tick();
        check("first_owner", 32'(u_if.owner), 32'b0001);
        check("first_gnt", 32'(u_if.gnt), 32'b0001);
        check("first_data", u_if.fifo_wr_data, word(0, 0));
        check_run(8);
        wait_drain(40);

`ifdef FIFO_ARB_BURST_EN
        // 3-word packet on req0 with req1 pending: handover without a bubble.
        load(0, 3);
        load(1, 1);
        push_seq(0, 0, 3);
        push_seq(1, 0, 1);
        tick();
        check("burst3_owner", 32'(u_if.owner), 32'b0001);
        check_run(4);
        wait_drain(40);

        // 20-word packet split at MAX_BURST=8, interleaved with req1's packet.
        load(0, 20);
        load(1, 2);
        push_seq(0, 0, 8);
        push_seq(1, 0, 2);
        push_seq(0, 8, 12);
        tick();
        check("split_owner", 32'(u_if.owner), 32'b0001);
        check_run(22);
        wait_drain(60);
`endif

        // Single requester: re-selected every cycle through the wrap.
        load(2, 5);
        push_seq(2, 0, 5);
        tick();
        check("single_owner", 32'(u_if.owner), 32'b0100);
        check_run(5);
        wait_drain(40);

        // Backpressure: full for 5 cycles after the first word.
        load(0, 3);
        push_seq(0, 0, 3);
        tick();
        check("bp_first_gnt", 32'(u_if.gnt), 32'b0001);
        tick();
        u_if.fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_gnt", 32'(u_if.gnt), 32'd0);
            check("bp_wr_en", 32'(u_if.fifo_wr_en), 32'd0);
            check("bp_owner", 32'(u_if.owner), 32'b0001);
`ifdef FIFO_ARB_BURST_EN
            check("bp_cnt", 32'(dut.r_burst_cnt), 32'd1);
`endif
            tick();
        end
        u_if.fifo_full = 1'b0;
        #1;
        check("bp_resume_gnt", 32'(u_if.gnt), 32'b0001);
        check("bp_resume_data", u_if.fifo_wr_data, word(0, 1));
        wait_drain(40);

        // Reset mid-operation after 5 accepted words from req2.
        load(2, 10);
        push_seq(2, 0, 5);
        tick();
        repeat (5) tick();
        check("mid_owner", 32'(u_if.owner), 32'b0100);
`ifdef FIFO_ARB_BURST_EN
        check("mid_cnt", 32'(dut.r_burst_cnt), 32'd5);
`endif
        rst = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(u_if.gnt), 32'd0);
        check("mid_rst_wr_en", 32'(u_if.fifo_wr_en), 32'd0);
        tick();
        check("mid_after_owner", 32'(u_if.owner), 32'd0);
        check("mid_after_gnt", 32'(u_if.gnt), 32'd0);
        check("mid_after_wr_en", 32'(u_if.fifo_wr_en), 32'd0);
        check("mid_after_data", u_if.fifo_wr_data, 32'd0);
        check("mid_after_rr", 32'(dut.r_rr_ptr), 32'd0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        apply();
        rst = 1'b0;
        #1;
        check("mid_post_gnt", 32'(u_if.gnt), 32'd0);
        repeat (4) tick();
        check("queue_empty", 32'(q_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
